// File: rtl/ulpi_pkg.sv
// Shared ULPI link definitions: FSM state encoding, command prefixes and the
// TX CMD byte builder used by the link FSM.
package ulpi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TXCMD = 3'd1,
        WDATA = 3'd2,
        XADDR = 3'd3,
        STP   = 3'd4,
        RTURN = 3'd5,
        RDATA = 3'd6,
        RX    = 3'd7
    } ulpi_state_e;

    localparam logic [7:0] ULPI_NOOP    = 8'h00;
    localparam logic [1:0] ULPI_REGW    = 2'b10;
    localparam logic [1:0] ULPI_REGR    = 2'b11;
    localparam logic [5:0] ULPI_EXT_ESC = 6'h2F;

    // RX FIFO entry layout: {last, cmd, data[7:0]}
    localparam int RX_W = 10;

    function automatic logic [7:0] txcmd_byte(input logic we, input logic ext,
                                              input logic [7:0] addr);
        logic [5:0] low;
        low = ext ? ULPI_EXT_ESC : addr[5:0];
        return {(we ? ULPI_REGW : ULPI_REGR), low};
    endfunction

endpackage

// File: rtl/ulpi_rx_fifo.sv
// Receive FIFO for bytes captured while the PHY owns the bus. Drops on full
// (unless a pop frees a slot the same cycle) and raises a sticky overflow flag.
module ulpi_rx_fifo
    import ulpi_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [RX_W-1:0] wr_data,
    input  logic            rd_en,
    output logic            rd_valid,
    output logic [RX_W-1:0] rd_data,
    output logic            ovf,
    input  logic            ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [RX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            do_push_s, do_pop_s;

    // Push/pop qualification, pointer and occupancy update, sticky overflow
    always_comb begin
        do_pop_s  = rd_en && (count_q != {CW{1'b0}});
        do_push_s = wr_en && ((count_q != FULL_CNT) || do_pop_s);
        wr_ptr_d  = do_push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // A dropped byte beats a clear arriving in the same cycle
        if (wr_en && !do_push_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Pointer, count and flag registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array; contents are don't-care while the entry is unoccupied
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_valid = (count_q != {CW{1'b0}});
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : {RX_W{1'b0}};
    assign ovf      = ovf_q;

endmodule

// File: rtl/ulpi_link.sv
// ULPI link-side controller: register read/write over the ULPI bus and capture
// of PHY-driven receive bursts into an RX FIFO.
module ulpi_link
    import ulpi_pkg::*;
#(
    parameter int EXT_ADDR    = 0,
    parameter int FIFO_DEPTH  = 16,
    parameter int NXT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_data_oe,
    input  logic       ulpi_dir,
    input  logic       ulpi_nxt,
    output logic       ulpi_stp,
    input  logic       reg_req,
    input  logic       reg_we,
    input  logic [7:0] reg_addr,
    input  logic [7:0] reg_wdata,
    output logic       reg_busy,
    output logic       reg_ack,
    output logic       reg_err,
    output logic [7:0] reg_rdata,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_cmd,
    output logic       rx_last,
    output logic       rx_ovf,
    input  logic       rx_ovf_clr
);

    ulpi_state_e state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        ext_q, ext_d;
    logic        busy_q, busy_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        dir_q, dir_d;
    logic [15:0] tmo_q, tmo_d;
    logic        abort_q, abort_d;
    logic        got_q, got_d;
    logic        stg_vld_q, stg_vld_d;
    logic [8:0]  stg_q, stg_d;

    logic            tmo_hit_s;
    logic            push_s;
    logic            fifo_wr_s;
    logic [RX_W-1:0] fifo_wdata_s;
    logic [RX_W-1:0] fifo_rdata_s;
    logic [7:0]      data_s;

    assign tmo_hit_s = (tmo_q == 16'(NXT_TIMEOUT));

    // Main FSM: next state, request latching, ack/err generation, nxt timeout
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        ext_d   = ext_q;
        busy_d  = ack_q ? 1'b0 : busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        tmo_d   = tmo_q;
        abort_d = abort_q;
        got_d   = got_q;
        case (state_q)
            IDLE: begin
                if (ulpi_dir) begin
                    state_d = RX;
                end else if (reg_req && !busy_q) begin
                    addr_d  = reg_addr;
                    wdata_d = reg_wdata;
                    we_d    = reg_we;
                    ext_d   = (EXT_ADDR != 0) && (reg_addr > 8'h3F);
                    busy_d  = 1'b1;
                    tmo_d   = 16'd0;
                    abort_d = 1'b0;
                    state_d = TXCMD;
                end else begin
                    state_d = IDLE;
                end
            end
            TXCMD, XADDR, WDATA: begin
                if (ulpi_dir) begin
                    // PHY grabbed the bus mid-command: abandon and receive
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    tmo_d   = 16'd0;
                    state_d = RX;
                end else if (ulpi_nxt) begin
                    tmo_d = 16'd0;
                    if (state_q == WDATA) begin
                        state_d = STP;
                    end else if (state_q == TXCMD && ext_q) begin
                        state_d = XADDR;
                    end else begin
                        state_d = we_q ? WDATA : RTURN;
                    end
                end else if (tmo_hit_s) begin
                    abort_d = 1'b1;
                    tmo_d   = 16'd0;
                    state_d = STP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            STP: begin
                ack_d   = 1'b1;
                err_d   = abort_q;
                abort_d = 1'b0;
                state_d = IDLE;
            end
            RTURN: begin
                if (ulpi_dir) begin
                    tmo_d   = 16'd0;
                    got_d   = 1'b0;
                    state_d = RDATA;
                end else if (tmo_hit_s) begin
                    abort_d = 1'b1;
                    tmo_d   = 16'd0;
                    state_d = STP;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            RDATA: begin
                if (ulpi_dir) begin
                    if (!got_q) begin
                        rdata_d = ulpi_data_i;
                        got_d   = 1'b1;
                    end else begin
                        got_d = got_q;
                    end
                end else begin
                    ack_d   = 1'b1;
                    got_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            RX: begin
                if (!ulpi_dir) begin
                    state_d = IDLE;
                end else begin
                    state_d = RX;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus byte selection; the byte stays put until the PHY asserts nxt
    always_comb begin
        data_s = ULPI_NOOP;
        case (state_q)
            TXCMD:   data_s = txcmd_byte(we_q, ext_q, addr_q);
            XADDR:   data_s = addr_q;
            WDATA:   data_s = wdata_q;
            default: data_s = ULPI_NOOP;
        endcase
    end

    // One-entry staging lets the final byte of a burst be tagged once dir drops
    always_comb begin
        dir_d        = ulpi_dir;
        push_s       = (state_q == RX) && ulpi_dir && dir_q;
        fifo_wr_s    = stg_vld_q && (push_s || !ulpi_dir);
        fifo_wdata_s = {!ulpi_dir, stg_q};
        if (push_s) begin
            stg_d     = {!ulpi_nxt, ulpi_data_i};
            stg_vld_d = 1'b1;
        end else if (!ulpi_dir) begin
            stg_d     = stg_q;
            stg_vld_d = 1'b0;
        end else begin
            stg_d     = stg_q;
            stg_vld_d = stg_vld_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            ext_q     <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= 8'h00;
            dir_q     <= 1'b0;
            tmo_q     <= 16'd0;
            abort_q   <= 1'b0;
            got_q     <= 1'b0;
            stg_vld_q <= 1'b0;
            stg_q     <= 9'h000;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            ext_q     <= ext_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            dir_q     <= dir_d;
            tmo_q     <= tmo_d;
            abort_q   <= abort_d;
            got_q     <= got_d;
            stg_vld_q <= stg_vld_d;
            stg_q     <= stg_d;
        end
    end

    ulpi_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr_s),
        .wr_data  (fifo_wdata_s),
        .rd_en    (rx_ready),
        .rd_valid (rx_valid),
        .rd_data  (fifo_rdata_s),
        .ovf      (rx_ovf),
        .ovf_clr  (rx_ovf_clr)
    );

    // Link releases the bus while the PHY drives it and for one turnaround cycle
    assign ulpi_data_oe = !ulpi_dir && !dir_q;
    assign ulpi_data_o  = data_s;
    assign ulpi_stp     = (state_q == STP);
    assign reg_busy     = busy_q;
    assign reg_ack      = ack_q;
    assign reg_err      = err_q;
    assign reg_rdata    = rdata_q;
    assign rx_last      = fifo_rdata_s[9];
    assign rx_cmd       = fifo_rdata_s[8];
    assign rx_data      = fifo_rdata_s[7:0];

endmodule

// File: tb/tb_ulpi_link.sv
// Scoreboard bench for ulpi_link: stimulus acts as the PHY and register client,
// a negedge monitor compares bus bytes, acks, RX pops and point probes.
`timescale 1ns/1ps
module tb_ulpi_link;

    localparam int T_OUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ulpi_data_i, ulpi_data_o;
    logic       ulpi_data_oe, ulpi_dir, ulpi_nxt, ulpi_stp;
    logic       reg_req, reg_we, reg_busy, reg_ack, reg_err;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       rx_valid, rx_ready, rx_cmd, rx_last, rx_ovf, rx_ovf_clr;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    ulpi_link #(
        .EXT_ADDR    (1),
        .FIFO_DEPTH  (4),
        .NXT_TIMEOUT (T_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ulpi_data_i  (ulpi_data_i),
        .ulpi_data_o  (ulpi_data_o),
        .ulpi_data_oe (ulpi_data_oe),
        .ulpi_dir     (ulpi_dir),
        .ulpi_nxt     (ulpi_nxt),
        .ulpi_stp     (ulpi_stp),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_busy     (reg_busy),
        .reg_ack      (reg_ack),
        .reg_err      (reg_err),
        .reg_rdata    (reg_rdata),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_data      (rx_data),
        .rx_cmd       (rx_cmd),
        .rx_last      (rx_last),
        .rx_ovf       (rx_ovf),
        .rx_ovf_clr   (rx_ovf_clr)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } probe_t;

    probe_t     probe_q[$];
    logic [8:0] exp_bus_q[$];   // {stp, data}
    logic [9:0] exp_ack_q[$];   // {check_rdata, err, rdata}
    logic [9:0] exp_rx_q[$];    // {last, cmd, data}
    int         n_cmp = 0;
    int         n_fail = 0;
    logic       end_req = 1'b0;
    logic       end_ack = 1'b0;

    // Monitor: all comparisons happen here, away from the active edge
    always @(negedge clk) begin
        probe_t      p;
        logic [15:0] act;
        logic [8:0]  eb;
        logic [9:0]  ea;
        logic [9:0]  er;
        while (probe_q.size() > 0) begin
            p = probe_q.pop_front();
            case (p.sel)
                0:       act = {6'd0, ulpi_data_o, ulpi_data_oe, ulpi_stp};
                1:       act = {5'd0, reg_busy, reg_ack, reg_err, reg_rdata};
                2:       act = {4'd0, rx_valid, rx_data, rx_cmd, rx_last, rx_ovf};
                3:       act = {15'd0, ulpi_data_oe};
                4:       act = {15'd0, rx_ovf};
                default: act = {15'd0, reg_busy};
            endcase
            n_cmp++;
            if (act !== p.exp) begin
                n_fail++;
                $display("FAIL probe %0s: got 0x%0h required 0x%0h", p.name, act, p.exp);
            end
        end
        if ((ulpi_nxt && ulpi_data_oe) || ulpi_stp) begin
            n_cmp++;
            if (exp_bus_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus: unexpected {stp,data}=0x%0h, none required", {ulpi_stp, ulpi_data_o});
            end else begin
                eb = exp_bus_q.pop_front();
                if ({ulpi_stp, ulpi_data_o} !== eb) begin
                    n_fail++;
                    $display("FAIL bus: got {stp,data}=0x%0h required 0x%0h", {ulpi_stp, ulpi_data_o}, eb);
                end
            end
        end
        if (reg_ack) begin
            n_cmp++;
            if (exp_ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack: unexpected reg_ack err=%0b, none required", reg_err);
            end else begin
                ea = exp_ack_q.pop_front();
                if (reg_err !== ea[8] || (ea[9] && reg_rdata !== ea[7:0])) begin
                    n_fail++;
                    $display("FAIL ack: got err=%0b rdata=0x%0h required err=%0b rdata=0x%0h",
                             reg_err, reg_rdata, ea[8], ea[7:0]);
                end
            end
        end
        if (rx_valid && rx_ready) begin
            n_cmp++;
            if (exp_rx_q.size() == 0) begin
                n_fail++;
                $display("FAIL rx: unexpected entry {last,cmd,data}=0x%0h, none required",
                         {rx_last, rx_cmd, rx_data});
            end else begin
                er = exp_rx_q.pop_front();
                if ({rx_last, rx_cmd, rx_data} !== er) begin
                    n_fail++;
                    $display("FAIL rx: got {last,cmd,data}=0x%0h required 0x%0h",
                             {rx_last, rx_cmd, rx_data}, er);
                end
            end
        end
        if (end_req && !end_ack) begin
            n_cmp++;
            if (exp_bus_q.size() + exp_ack_q.size() + exp_rx_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: leftover bus=%0d ack=%0d rx=%0d required 0",
                         exp_bus_q.size(), exp_ack_q.size(), exp_rx_q.size());
            end
            end_ack = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input int sel, input logic [15:0] exp);
        probe_t p;
        p.name = nm;
        p.sel  = sel;
        p.exp  = exp;
        probe_q.push_back(p);
    endtask

    task automatic phy_accept(input int waits);
        ulpi_nxt = 1'b0;
        repeat (waits) step();
        ulpi_nxt = 1'b1;
        step();
        ulpi_nxt = 1'b0;
    endtask

    task automatic reg_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        reg_req   = 1'b1;
        reg_we    = we;
        reg_addr  = addr;
        reg_wdata = wdata;
        step();
        reg_req   = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (reg_busy && i < 60) begin
            step();
            i++;
        end
        probe(nm, 5, 16'h0000);
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic n);
        ulpi_data_i = d;
        ulpi_nxt    = n;
        step();
    endtask

    task automatic rx_start();
        ulpi_dir    = 1'b1;
        ulpi_nxt    = 1'b1;
        ulpi_data_i = 8'hFF;
        step();
    endtask

    task automatic rx_end();
        ulpi_dir    = 1'b0;
        ulpi_nxt    = 1'b0;
        ulpi_data_i = 8'h00;
        step();
    endtask

    initial begin
        rst = 1'b0; ulpi_data_i = 8'h00; ulpi_dir = 1'b0; ulpi_nxt = 1'b0;
        reg_req = 1'b0; reg_we = 1'b0; reg_addr = 8'h00; reg_wdata = 8'h00;
        rx_ready = 1'b1; rx_ovf_clr = 1'b0;
        repeat (3) step();
        probe("rst_bus", 0, 16'h0002);
        probe("rst_reg", 1, 16'h0000);
        probe("rst_rx", 2, 16'h0000);
        step();
        rst = 1'b1;
        step();

        // Register write 0x0A <= 0x55, PHY waits two cycles per byte
        exp_bus_q.push_back({1'b0, 8'h8A});
        exp_bus_q.push_back({1'b0, 8'h55});
        exp_bus_q.push_back({1'b1, 8'h00});
        exp_ack_q.push_back({1'b0, 1'b0, 8'h00});
        reg_op(1'b1, 8'h0A, 8'h55);
        probe("busy_after_accept", 5, 16'h0001);
        phy_accept(2);
        phy_accept(2);
        wait_idle("wr_idle");

        // Register read 0x00, PHY returns 0x24
        exp_bus_q.push_back({1'b0, 8'hC0});
        exp_ack_q.push_back({1'b1, 1'b0, 8'h24});
        reg_op(1'b0, 8'h00, 8'h00);
        phy_accept(1);
        ulpi_dir = 1'b1; ulpi_data_i = 8'hEE;
        probe("oe_dir_high", 3, 16'h0000);
        step();
        ulpi_data_i = 8'h24;
        step();
        ulpi_dir = 1'b0; ulpi_data_i = 8'h00;
        probe("oe_turnaround", 3, 16'h0000);
        step();
        probe("oe_restored", 3, 16'h0001);
        wait_idle("rd_idle");

        // Extended address write 0x80 <= 0x11
        exp_bus_q.push_back({1'b0, 8'hAF});
        exp_bus_q.push_back({1'b0, 8'h80});
        exp_bus_q.push_back({1'b0, 8'h11});
        exp_bus_q.push_back({1'b1, 8'h00});
        exp_ack_q.push_back({1'b0, 1'b0, 8'h00});
        reg_op(1'b1, 8'h80, 8'h11);
        phy_accept(1);
        phy_accept(1);
        phy_accept(1);
        wait_idle("xwr_idle");

        // dir rises before TX CMD is accepted: abort, then burst captured
        exp_ack_q.push_back({1'b0, 1'b1, 8'h00});
        exp_rx_q.push_back({1'b0, 1'b1, 8'h2E});
        exp_rx_q.push_back({1'b1, 1'b0, 8'h99});
        reg_op(1'b1, 8'h05, 8'h77);
        ulpi_dir = 1'b1; ulpi_nxt = 1'b0; ulpi_data_i = 8'hEE;
        step();
        rx_byte(8'h2E, 1'b0);
        rx_byte(8'h99, 1'b1);
        rx_end();
        wait_idle("abort_idle");
        repeat (4) step();

        // RX burst from idle: RX CMD then two data bytes
        exp_rx_q.push_back({1'b0, 1'b1, 8'h4D});
        exp_rx_q.push_back({1'b0, 1'b0, 8'hC3});
        exp_rx_q.push_back({1'b1, 1'b0, 8'h01});
        rx_start();
        rx_byte(8'h4D, 1'b0);
        rx_byte(8'hC3, 1'b1);
        rx_byte(8'h01, 1'b1);
        rx_end();
        repeat (5) step();

        // Overflow: six bytes into a four-entry FIFO with no reader
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_rx_q.push_back({2'b00, 8'(16 + i)});
        rx_start();
        for (int i = 0; i < 6; i++) rx_byte(8'(16 + i), 1'b1);
        rx_end();
        probe("ovf_head", 2, 16'h0881);
        repeat (3) step();
        probe("ovf_sticky", 4, 16'h0001);
        rx_ovf_clr = 1'b1;
        step();
        rx_ovf_clr = 1'b0;
        probe("ovf_cleared", 4, 16'h0000);
        rx_ready = 1'b1;
        repeat (8) step();

        // nxt never comes: abort after NXT_TIMEOUT+1 waiting cycles
        exp_bus_q.push_back({1'b1, 8'h00});
        exp_ack_q.push_back({1'b0, 1'b1, 8'h00});
        reg_op(1'b1, 8'h01, 8'h02);
        repeat (T_OUT) step();
        probe("tmo_still_waiting", 0, 16'h0206);
        wait_idle("tmo_idle");

        // Reset mid-operation with FIFO contents present
        rx_ready = 1'b0;
        rx_start();
        rx_byte(8'h31, 1'b1);
        rx_byte(8'h32, 1'b1);
        rx_end();
        probe("fifo_before_rst", 2, 16'h0988);
        reg_op(1'b1, 8'h07, 8'h08);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        probe("midrst_reg", 1, 16'h0000);
        probe("midrst_rx", 2, 16'h0000);
        probe("midrst_bus", 0, 16'h0002);
        repeat (4) step();

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
